// File: rtl/mem_ctrl_param_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the parametrised picorv32 on-chip RAM slave:
//   - XLEN / STRB : native memory interface data width and byte-lane count
//   - state_t     : controller FSM states (IDLE, WAIT, RESP)
//   - decode_w()  : width of the address tag compared by the window decoder
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam int XLEN = 32;
   localparam int STRB = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Address bits above the word index and the two byte-offset bits form
   // the tag that selects this instance's window.
   function automatic int decode_w(input int aw);
      return XLEN - aw - 2;
   endfunction

endpackage

// File: rtl/mem_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// mem_ctrl_param_if
// picorv32 native memory bus as seen by one slave.
//   mem_valid  : request valid, held by the CPU until mem_ready
//   mem_instr  : instruction-fetch flag
//   mem_wstrb  : byte write enables, 0 for a read
//   mem_wdata  : write data, little-endian lanes
//   mem_addr   : byte address
//   mem_ready  : one-cycle completion pulse (slave -> CPU)
//   mem_rdata  : read data, zero whenever mem_ready is low (slave -> CPU)
// ---------------------------------------------------------------------------
interface mem_ctrl_param_if;
   import mem_pkg::*;

   logic            mem_valid;
   logic            mem_instr;
   logic [STRB-1:0] mem_wstrb;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_addr;
   logic            mem_ready;
   logic [XLEN-1:0] mem_rdata;

   modport master (
      output mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/mem_ctrl_param_ram_bytewise.sv
// ---------------------------------------------------------------------------
// ram_bytewise
// Single-port synchronous RAM with per-byte write enables, written so that
// synthesis infers block RAM.
//   clk   : rising-edge clock
//   en    : access enable; rdata only updates on enabled cycles
//   addr  : word address
//   wstrb : byte write enables (bit i -> bits 8i+7:8i)
//   wdata : write data
//   rdata : read data, one-cycle latency, returns the word as it was before
//           a write issued on the same edge (read-before-write)
// Contents are never reset.
// ---------------------------------------------------------------------------
module ram_bytewise
   import mem_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            en,
   input  logic [AW-1:0]   addr,
   input  logic [STRB-1:0] wstrb,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int i = 0; i < STRB; i++) begin
            if (wstrb[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/mem_ctrl_param.sv
// ---------------------------------------------------------------------------
// mem_ctrl_param
// Parametrised on-chip RAM slave for the picorv32 native memory interface.
// Decodes its own address window, inserts WAIT_STATES extra cycles before
// the mem_ready pulse, and drives an OR-able bus (all zero when not
// responding) so several instances can share one CPU port.
//   clk         : system clock, rising edge
//   resetn      : asynchronous active-low reset
//   bus         : native memory bus, slave side
//   sel         : combinational, request is valid and hits this window
//   fetch_count : completed instruction fetches, wrapping
// ---------------------------------------------------------------------------
module mem_ctrl_param
   import mem_pkg::*;
#(
   parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int              DEPTH_WORDS = 4096,
   parameter int              WAIT_STATES = 0,
   localparam int             AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            resetn,
   mem_ctrl_param_if.slave bus,
   output logic            sel,
   output logic [XLEN-1:0] fetch_count
);

   localparam int         DW      = decode_w(AW);
   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

   state_t          state;
   logic [3:0]      wcnt;
   logic            ready_q;
   logic [XLEN-1:0] fetch_cnt_q;
   logic            instr_q;
   logic            rd_q;
   logic            accept;
   logic [DW-1:0]   tag;
   logic [AW-1:0]   widx;
   logic [XLEN-1:0] ram_rdata;
   logic            unused_byte_offset;

   // Window decode; the byte offset never matters for word accesses.
   assign tag                = bus.mem_addr[XLEN-1:AW+2];
   assign widx               = bus.mem_addr[AW+1:2];
   assign unused_byte_offset = ^bus.mem_addr[1:0];
   assign sel                = bus.mem_valid & (tag == BASE_ADDR[XLEN-1:AW+2]);
   assign accept             = (state == IDLE) & sel;

   // The RAM is touched only at the accept edge: the write commits and the
   // old word is captured in the RAM output register, which then holds
   // through WAIT/RESP because no further access is enabled.
   ram_bytewise #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .en    (accept),
      .addr  (widx),
      .wstrb (bus.mem_wstrb),
      .wdata (bus.mem_wdata),
      .rdata (ram_rdata)
   );

   // Request attributes needed after the accept edge; the CPU may change the
   // live bus during WAIT, so only these captured copies are trusted.
   always_ff @(posedge clk) begin
      if (accept) begin
         instr_q <= bus.mem_instr;
         rd_q    <= (bus.mem_wstrb == '0);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         wcnt        <= '0;
         ready_q     <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel) begin
                  wcnt <= WS_LOAD;
                  if (WAIT_STATES > 0) begin
                     state <= WAIT;
                  end else begin
                     state   <= RESP;
                     ready_q <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (wcnt == 4'd0) begin
                  state   <= RESP;
                  ready_q <= 1'b1;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            RESP: begin
               state   <= IDLE;
               ready_q <= 1'b0;
               if (instr_q && rd_q) begin
                  fetch_cnt_q <= fetch_cnt_q + 32'd1;
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Both operands are flops, so the bus sees a registered word that is
   // forced to zero outside the RESP cycle (OR-able bus).
   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = ram_rdata & {XLEN{ready_q}};
   assign fetch_count   = fetch_cnt_q;

endmodule

// File: tb/tb_mem_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl_param
// Three mem_ctrl_param instances with disjoint windows share one CPU-side
// stimulus bus:
//   A: BASE 0x0001_0000, 1024 words, 0 wait states
//   B: BASE 0x0000_0000, 4096 words, 3 wait states
//   C: BASE 0x0002_0000,   64 words, 4 wait states
// Expected data comes from a word-addressed associative-array model of the
// memory map plus per-instance fetch counters.
// ---------------------------------------------------------------------------
module tb_mem_ctrl_param;
   import mem_pkg::*;

   logic        clk    = 1'b0;
   logic        rstn   = 1'b0;
   logic        valid  = 1'b0;
   logic        instr  = 1'b0;
   logic [3:0]  wstrb  = 4'h0;
   logic [31:0] wdata  = 32'h0;
   logic [31:0] addr   = 32'h0;

   always #5 clk = ~clk;

   mem_ctrl_param_if bus_a ();
   mem_ctrl_param_if bus_b ();
   mem_ctrl_param_if bus_c ();

   assign bus_a.mem_valid = valid;
   assign bus_a.mem_instr = instr;
   assign bus_a.mem_wstrb = wstrb;
   assign bus_a.mem_wdata = wdata;
   assign bus_a.mem_addr  = addr;
   assign bus_b.mem_valid = valid;
   assign bus_b.mem_instr = instr;
   assign bus_b.mem_wstrb = wstrb;
   assign bus_b.mem_wdata = wdata;
   assign bus_b.mem_addr  = addr;
   assign bus_c.mem_valid = valid;
   assign bus_c.mem_instr = instr;
   assign bus_c.mem_wstrb = wstrb;
   assign bus_c.mem_wdata = wdata;
   assign bus_c.mem_addr  = addr;

   logic [2:0]  sel_w;
   logic [2:0]  rdy;
   logic [31:0] rd [3];
   logic [31:0] fc [3];

   assign rdy[0] = bus_a.mem_ready;
   assign rdy[1] = bus_b.mem_ready;
   assign rdy[2] = bus_c.mem_ready;
   assign rd[0]  = bus_a.mem_rdata;
   assign rd[1]  = bus_b.mem_rdata;
   assign rd[2]  = bus_c.mem_rdata;

   mem_ctrl_param #(.BASE_ADDR(32'h0001_0000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_a (
      .clk(clk), .resetn(rstn), .bus(bus_a), .sel(sel_w[0]), .fetch_count(fc[0]));
   mem_ctrl_param #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(4096), .WAIT_STATES(3)) dut_b (
      .clk(clk), .resetn(rstn), .bus(bus_b), .sel(sel_w[1]), .fetch_count(fc[1]));
   mem_ctrl_param #(.BASE_ADDR(32'h0002_0000), .DEPTH_WORDS(64), .WAIT_STATES(4)) dut_c (
      .clk(clk), .resetn(rstn), .bus(bus_c), .sel(sel_w[2]), .fetch_count(fc[2]));

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [31:0] mdl [int unsigned];
   logic [31:0] fc_m [3];

   function automatic int ws_of(input int i);
      case (i)
         0:       return 0;
         1:       return 3;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] base_of(input int i);
      case (i)
         0:       return 32'h0001_0000;
         1:       return 32'h0000_0000;
         default: return 32'h0002_0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transaction to instance `inst`. Read data is checked only
   // when the model knows the word; writes to unknown words are always full.
   task automatic access(input int inst, input logic [31:0] a, input logic [3:0] ws,
                         input logic [31:0] wd, input logic ins, input string tag);
      int unsigned w;
      logic [31:0] old;
      logic [31:0] nw;
      bit          known;
      int          lat;
      w     = a >> 2;
      known = mdl.exists(w);
      old   = known ? mdl[w] : 32'h0;
      @(negedge clk);
      valid = 1'b1; addr = a; wstrb = ws; wdata = wd; instr = ins;
      #1;
      check({tag, ".sel"}, 32'(sel_w[inst]), 32'd1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rdy[inst] && lat < 40);
      check({tag, ".lat"}, 32'(lat), 32'(1 + ws_of(inst)));
      if (known) check({tag, ".rdata"}, rd[inst], old);
      valid = 1'b0; wstrb = 4'h0; instr = 1'b0;
      nw = old;
      for (int i = 0; i < 4; i++) if (ws[i]) nw[8*i +: 8] = wd[8*i +: 8];
      if (ws != 4'h0 && (known || ws == 4'hF)) mdl[w] = nw;
      if (ins && ws == 4'h0) fc_m[inst] = fc_m[inst] + 32'd1;
      @(negedge clk);
      check({tag, ".idle_ready"}, 32'(rdy[inst]), 32'd0);
      check({tag, ".idle_rdata"}, rd[inst], 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic        seen;
      logic        bad;
      int          inst;
      logic [3:0]  ws;
      fc_m[0] = 32'd0; fc_m[1] = 32'd0; fc_m[2] = 32'd0;

      // Reset state
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("reset.ready", 32'(rdy[i]), 32'd0);
         check("reset.rdata", rd[i], 32'd0);
         check("reset.fetch", fc[i], 32'd0);
      end
      rstn = 1'b1;

      // Initialise words 0..15 of every window
      for (int i = 0; i < 3; i++)
         for (int w = 0; w < 16; w++)
            access(i, base_of(i) + 32'(w * 4), 4'hF, $urandom, 1'b0, "init");

      // Single read, zero wait states
      access(0, 32'h0001_0014, 4'hF, 32'hDEAD_BEEF, 1'b0, "preload5");
      access(0, 32'h0001_0014, 4'h0, 32'h0, 1'b0, "read5");
      check("read5.model", mdl[32'h0001_0014 >> 2], 32'hDEAD_BEEF);

      // Byte-lane write: old data returned, then merged word read back
      access(0, 32'h0001_000C, 4'hF, 32'h0, 1'b0, "clear3");
      access(0, 32'h0001_000C, 4'b0101, 32'h1122_3344, 1'b0, "bytewr3");
      access(0, 32'h0001_000C, 4'h0, 32'h0, 1'b0, "read3");
      check("read3.merged", mdl[32'h0001_000C >> 2], 32'h0022_0044);

      // Out of window: nobody answers, bus stays zero
      @(negedge clk);
      valid = 1'b1; addr = 32'h0001_1000; wstrb = 4'h0;
      #1;
      check("oow.sel", 32'(sel_w), 32'd0);
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (rdy != 3'b000 || rd[0] != 32'h0) bad = 1'b1;
      end
      check("oow.quiet", 32'(bad), 32'd0);
      valid = 1'b0;
      access(0, 32'h0001_0FFC, 4'hF, 32'hCAFE_F00D, 1'b0, "lastwr");
      access(0, 32'h0001_0FFC, 4'h0, 32'h0, 1'b0, "lastrd");

      // Wait states: single read then back-to-back with valid held high
      access(1, 32'h0000_0008, 4'h0, 32'h0, 1'b0, "ws3.read");
      @(negedge clk);
      valid = 1'b1; addr = 32'h0000_0000; wstrb = 4'h0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rdy[1] && lat < 40);
      check("b2b.first_lat", 32'(lat), 32'd4);
      check("b2b.first_rdata", rd[1], mdl[0]);
      addr = 32'h0000_0004;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rdy[1] && lat < 40);
      check("b2b.spacing", 32'(lat), 32'd5);
      check("b2b.second_rdata", rd[1], mdl[1]);
      valid = 1'b0;
      @(negedge clk);

      // Fetch counter: 10 fetches, 3 data reads, 1 instr-flagged write
      for (int k = 0; k < 10; k++)
         access(0, 32'h0001_0000 + 32'($urandom_range(0, 15) * 4), 4'h0, 32'h0, 1'b1, "fetch");
      for (int k = 0; k < 3; k++)
         access(0, 32'h0001_0000 + 32'($urandom_range(0, 15) * 4), 4'h0, 32'h0, 1'b0, "dread");
      access(0, 32'h0001_0020, 4'hF, $urandom, 1'b1, "instr_wr");
      check("fetch.count10", fc[0], 32'd10);

      // Fetch counter wrap
      @(negedge clk);
      force dut_a.fetch_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut_a.fetch_cnt_q;
      #1;
      check("fetch.forced", fc[0], 32'hFFFF_FFFF);
      fc_m[0] = 32'hFFFF_FFFF;
      access(0, 32'h0001_0008, 4'h0, 32'h0, 1'b1, "wrapfetch");
      @(negedge clk);
      check("fetch.wrap", fc[0], fc_m[0]);
      check("fetch.wrap_zero", fc[0], 32'd0);

      // Reset during WAIT: write already committed, no ready pulse
      @(negedge clk);
      valid = 1'b1; addr = 32'h0002_001C; wstrb = 4'hF; wdata = 32'hA5A5_5A5A; instr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      mdl[32'h0002_001C >> 2] = 32'hA5A5_5A5A;
      fc_m[0] = 32'd0; fc_m[1] = 32'd0; fc_m[2] = 32'd0;
      #1;
      seen = rdy[2];
      repeat (3) begin @(negedge clk); seen |= rdy[2]; end
      valid = 1'b0; wstrb = 4'h0;
      rstn = 1'b1;
      repeat (6) begin @(negedge clk); seen |= rdy[2]; end
      check("rstmid.no_ready", 32'(seen), 32'd0);
      check("rstmid.state_idle", 32'(dut_c.state), 32'(IDLE));
      check("rstmid.fetch_a", fc[0], 32'd0);
      access(2, 32'h0002_001C, 4'h0, 32'h0, 1'b1, "rstmid.read");

      // Randomised traffic across all windows
      for (int k = 0; k < 40; k++) begin
         inst = int'($urandom_range(0, 2));
         ws   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         access(inst, base_of(inst) + 32'($urandom_range(0, 15) * 4), ws, $urandom,
                1'($urandom), "rand");
      end
      for (int i = 0; i < 3; i++) check("rand.fetch", fc[i], fc_m[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
